// File: rtl/ebus_ctl.sv
// EBUS transfer controller: round-robin arbitration among requesters, function setup,
// demand/transfer handshake with devices, and demand-phase timeout.
module ebus_ctl #(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 64
) (
    input  logic                  clk,
    input  logic                  resetN,
    input  logic [NREQ-1:0]       req,
    input  logic [3*NREQ-1:0]     reqFunc,
    input  logic [NREQ-1:0]       reqDataIn,
    input  logic                  ebusXfer,
    output logic [NREQ-1:0]       grant,
    output logic [2:0]            ebusFunc,
    output logic                  ebusDemand,
    output logic                  CONIorDATAI,
    output logic                  ebusLatch,
    output logic [NREQ-1:0]       done,
    output logic                  timeoutErr,
    output logic                  busy
);

    localparam int         IW       = $clog2(NREQ);
    localparam int         FW       = 3;
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SETUP   = 3'd1,
        DEMAND  = 3'd2,
        XFER    = 3'd3,
        RELEASE = 3'd4
    } state_t;

    state_t          state_r, state_s;
    logic [NREQ-1:0] grant_r, grant_s;
    logic [2:0]      func_r, func_s;
    logic            coni_r, coni_s;
    logic            demand_r, demand_s;
    logic            latch_r, latch_s;
    logic [NREQ-1:0] done_r, done_s;
    logic            timeoutErr_r, timeoutErr_s;
    logic            busy_r, busy_s;
    logic [7:0]      cnt_r, cnt_s;
    logic [IW-1:0]   ptr_r, ptr_s;
    logic [IW-1:0]   pick_s;
    logic [IW-1:0]   idx_s;
    logic            pickValid_s;

    // Round-robin search: first requesting index at or after the pointer, with wrap.
    always_comb begin
        pickValid_s = 1'b0;
        pick_s      = ptr_r;
        idx_s       = ptr_r;
        for (int off = 0; off < NREQ; off++) begin
            idx_s = ptr_r + IW'(off);
            if (!pickValid_s && req[idx_s]) begin
                pickValid_s = 1'b1;
                pick_s      = idx_s;
            end else begin
                pickValid_s = pickValid_s;
            end
        end
    end

    // Next-state and next-output logic; every output is registered from these values.
    always_comb begin
        state_s      = state_r;
        grant_s      = grant_r;
        func_s       = func_r;
        coni_s       = coni_r;
        demand_s     = 1'b0;
        latch_s      = 1'b0;
        done_s       = '0;
        timeoutErr_s = 1'b0;
        cnt_s        = cnt_r;
        ptr_s        = ptr_r;

        case (state_r)
            IDLE: begin
                if (pickValid_s) begin
                    state_s = SETUP;
                    grant_s = {{(NREQ-1){1'b0}}, 1'b1} << pick_s;
                    func_s  = reqFunc[FW*int'(pick_s) +: FW];
                    coni_s  = reqDataIn[pick_s];
                    ptr_s   = pick_s + IW'(1);
                end else begin
                    state_s = IDLE;
                    grant_s = '0;
                    func_s  = 3'd0;
                    coni_s  = 1'b0;
                end
            end
            SETUP: begin
                // Device strobe of ebusXfer here is deliberately not looked at.
                state_s  = DEMAND;
                demand_s = 1'b1;
                cnt_s    = 8'd0;
            end
            DEMAND: begin
                if (ebusXfer) begin
                    state_s  = XFER;
                    demand_s = 1'b1;
                    latch_s  = coni_r;
                    done_s   = grant_r;
                end else if (cnt_r == CNT_LAST) begin
                    state_s      = RELEASE;
                    timeoutErr_s = 1'b1;
                    done_s       = grant_r;
                    grant_s      = '0;
                    func_s       = 3'd0;
                    coni_s       = 1'b0;
                end else begin
                    demand_s = 1'b1;
                    cnt_s    = cnt_r + 8'd1;
                end
            end
            XFER: begin
                state_s = RELEASE;
                grant_s = '0;
                func_s  = 3'd0;
                coni_s  = 1'b0;
            end
            RELEASE: begin
                // Wait for the device to let go of ebusXfer before re-arbitrating.
                if (!ebusXfer) begin
                    state_s = IDLE;
                end else begin
                    state_s = RELEASE;
                end
            end
            default: begin
                state_s = IDLE;
                grant_s = '0;
                func_s  = 3'd0;
                coni_s  = 1'b0;
                cnt_s   = 8'd0;
            end
        endcase

        busy_s = (state_s != IDLE);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!resetN) begin
            state_r      <= IDLE;
            grant_r      <= '0;
            func_r       <= 3'd0;
            coni_r       <= 1'b0;
            demand_r     <= 1'b0;
            latch_r      <= 1'b0;
            done_r       <= '0;
            timeoutErr_r <= 1'b0;
            busy_r       <= 1'b0;
            cnt_r        <= 8'd0;
            ptr_r        <= '0;
        end else begin
            state_r      <= state_s;
            grant_r      <= grant_s;
            func_r       <= func_s;
            coni_r       <= coni_s;
            demand_r     <= demand_s;
            latch_r      <= latch_s;
            done_r       <= done_s;
            timeoutErr_r <= timeoutErr_s;
            busy_r       <= busy_s;
            cnt_r        <= cnt_s;
            ptr_r        <= ptr_s;
        end
    end

    assign grant       = grant_r;
    assign ebusFunc    = func_r;
    assign ebusDemand  = demand_r;
    assign CONIorDATAI = coni_r;
    assign ebusLatch   = latch_r;
    assign done        = done_r;
    assign timeoutErr  = timeoutErr_r;
    assign busy        = busy_r;

endmodule

// File: doc/ebus_ctl.md
EBUS_CTL -- requirements
Module: ebus_ctl

Interface
REQ-001 Parameter NREQ, default 4: number of EBUS requesters (fixed at 4 for this revision).
REQ-002 Parameter TIMEOUT, default 64: demand-phase cycles before the transfer is abandoned (range 2..255).
REQ-003 clk  in  1  single system clock; all state changes on rising edge.
REQ-004 resetN  in  1  synchronous, active-low reset, sampled on rising edge of clk.
REQ-005 req  in  4  per-requester EBUS request, level, held until done/timeout seen; bit 0 = requester 0.
REQ-006 reqFunc  in  12  per-requester 3-bit EBUS function, requester n in bits [3n:3n+2].
REQ-007 reqDataIn  in  4  per-requester flag: 1 = CONI/DATAI (device drives bus), 0 = CONO/DATAO/other.
REQ-008 ebusXfer  in  1  device transfer acknowledge.
REQ-009 grant  out  4  one-hot grant to the owning requester, all zero when idle.
REQ-010 ebusFunc  out  3  function of the granted requester, zero when no grant.
REQ-011 ebusDemand  out  1  demand strobe to devices.
REQ-012 CONIorDATAI  out  1  granted transfer is device-to-processor.
REQ-013 ebusLatch  out  1  one-cycle pulse: capture EBUS data (input transfers only).
REQ-014 done  out  4  one-cycle completion pulse to the owning requester.
REQ-015 timeoutErr  out  1  one-cycle pulse when a transfer times out.
REQ-016 busy  out  1  high in every state except IDLE.

Function
REQ-017 The controller SHALL implement states IDLE, SETUP, DEMAND, XFER, RELEASE.
REQ-018 IDLE: if any req bit is set, SHALL grant one requester by round-robin starting at the index after the last granted one (requester 0 first after reset) and go to SETUP next cycle.
REQ-019 grant, ebusFunc and CONIorDATAI SHALL be registered at grant and held constant through SETUP, DEMAND and XFER.
REQ-020 SETUP SHALL last exactly one cycle (function setup time) with ebusDemand low, then go to DEMAND.
REQ-021 DEMAND: ebusDemand SHALL be high; a 8-bit counter cleared on entry SHALL increment each cycle.
REQ-022 DEMAND with ebusXfer=1 SHALL go to XFER; ebusXfer takes priority over timeout in the same cycle.
REQ-023 DEMAND with counter reaching TIMEOUT-1 and ebusXfer=0 SHALL pulse timeoutErr and done for the owner and go to RELEASE.
REQ-024 XFER SHALL last one cycle: ebusDemand high, ebusLatch pulsed iff CONIorDATAI=1, done pulsed for the owner; then RELEASE.
REQ-025 RELEASE SHALL drop grant, ebusDemand and ebusFunc and return to IDLE only after ebusXfer=0 (device released bus).
REQ-026 Minimum transaction: grant-to-done latency 3 cycles (SETUP, one DEMAND cycle, XFER); minimum gap between grants 1 IDLE cycle.
REQ-027 A requester dropping req before done SHALL NOT abort the transaction; it completes normally.
REQ-028 Requests arriving during a transaction SHALL wait; no preemption.
REQ-029 All four requesting in IDLE with last owner 3 SHALL grant requester 0 (wrap-around).
REQ-030 ebusXfer high in IDLE or SETUP SHALL be ignored.
REQ-031 done and timeoutErr SHALL never be high for more than one consecutive cycle.

Reset
REQ-032 resetN=0 at any clock edge, including mid-transaction, SHALL force IDLE with grant=0, ebusFunc=0, ebusDemand=0, CONIorDATAI=0, ebusLatch=0, done=0, timeoutErr=0, busy=0, counter=0, round-robin pointer to requester 0.
REQ-033 No done pulse SHALL be issued for a transaction aborted by reset.

Verification
REQ-034 req=0001, reqFunc[0:2]=3'b101, reqDataIn=0001, ebusXfer at 2nd DEMAND cycle -> grant=0001, ebusFunc=5, CONIorDATAI=1, ebusLatch and done[0] one pulse, busy low after RELEASE.
REQ-035 req=1111 held, ebusXfer immediately -> grants in order 0001,0010,0100,1000,0001, each gap one IDLE cycle.
REQ-036 req=0100, ebusXfer never -> ebusDemand high exactly 64 cycles, timeoutErr and done[2] pulse together, grant clears.
REQ-037 ebusXfer rising on the cycle counter=TIMEOUT-1 -> XFER taken, timeoutErr stays 0.
REQ-038 resetN low during DEMAND -> next cycle all outputs zero, no done; after release req=1000,0001 both set -> requester 0 granted first.
